// File: rtl/rv32i_boot_ctrl.sv
// rtl/rv32i_boot_ctrl.sv - program loader and run supervisor for an RV32I core
// Optional run-phase watchdog enabled by defining BOOT_CTRL_WATCHDOG_EN.
module rv32i_boot_ctrl #(
    parameter int IMEM_WORDS = 256,
    parameter int WDT_CYCLES = 100000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          load_valid,
    output logic                          load_ready,
    input  logic [31:0]                   load_data,
    input  logic                          load_last,
    output logic                          imem_we,
    output logic [$clog2(IMEM_WORDS)-1:0] imem_addr,
    output logic [31:0]                   imem_wdata,
    output logic                          core_rst_n,
    input  logic                          core_halted,
    output logic                          busy,
    output logic                          done,
    output logic                          error,
    output logic [1:0]                    err_code,
    output logic [31:0]                   cycle_count,
    output logic [15:0]                   load_count
);

    localparam int AW = $clog2(IMEM_WORDS);
    localparam logic [31:0] WDT_LIMIT = 32'(WDT_CYCLES);
`ifdef BOOT_CTRL_WATCHDOG_EN
    localparam bit WDT_EN = 1'b1;
`else
    localparam bit WDT_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE,
        S_ERR
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [15:0]     load_count_q, load_count_d;
    logic [31:0]     cycle_count_q, cycle_count_d;
    logic [1:0]      err_code_q, err_code_d;
    logic            accept;
    logic            last_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            addr_q        <= '0;
            load_count_q  <= '0;
            cycle_count_q <= '0;
            err_code_q    <= '0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            load_count_q  <= load_count_d;
            cycle_count_q <= cycle_count_d;
            err_code_q    <= err_code_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        load_count_d  = load_count_q;
        cycle_count_d = cycle_count_q;
        err_code_d    = err_code_q;

        load_ready = (state_q == S_LOAD);
        accept     = load_ready && load_valid;
        last_addr  = (addr_q == AW'(IMEM_WORDS - 1));
        imem_we    = accept;
        imem_addr  = addr_q;
        imem_wdata = accept ? load_data : 32'd0;
        core_rst_n = (state_q == S_RUN) || (state_q == S_DONE);
        busy       = (state_q == S_LOAD) || (state_q == S_RUN);
        done       = (state_q == S_DONE);
        error      = (state_q == S_ERR);

        case (state_q)
            S_LOAD: begin
                if (accept) begin
                    load_count_d = load_count_q + 16'd1;
                    // Counter parks at the top address instead of wrapping.
                    addr_d = last_addr ? addr_q : addr_q + AW'(1);
                    if (load_last) begin
                        state_d = S_RUN;
                    end else if (last_addr) begin
                        state_d    = S_ERR;
                        err_code_d = 2'b01;
                    end
                end
            end
            S_RUN: begin
                // Halt wins over a watchdog expiry seen in the same cycle.
                if (core_halted) begin
                    state_d = S_DONE;
                end else if (WDT_EN && (cycle_count_q >= WDT_LIMIT)) begin
                    state_d    = S_ERR;
                    err_code_d = 2'b10;
                end else if (cycle_count_q != 32'hFFFF_FFFF) begin
                    cycle_count_d = cycle_count_q + 32'd1;
                end
            end
            default: begin
                if (start) begin
                    state_d       = S_LOAD;
                    addr_d        = '0;
                    load_count_d  = '0;
                    cycle_count_d = '0;
                    err_code_d    = '0;
                end
            end
        endcase

        err_code    = err_code_q;
        cycle_count = cycle_count_q;
        load_count  = load_count_q;
    end

endmodule

// File: tb/tb_rv32i_boot_ctrl.sv
// tb/tb_rv32i_boot_ctrl.sv - scoreboard bench for rv32i_boot_ctrl
module tb_rv32i_boot_ctrl;

    localparam int IW  = 8;
    localparam int AW  = 3;
    localparam int WDT = 60;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          load_valid = 1'b0;
    logic          load_ready;
    logic [31:0]   load_data = '0;
    logic          load_last = 1'b0;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          core_rst_n;
    logic          core_halted = 1'b0;
    logic          busy, done, error;
    logic [1:0]    err_code;
    logic [31:0]   cycle_count;
    logic [15:0]   load_count;

    int n_checks = 0;
    int n_pass   = 0;
    logic [AW+31:0] exp_q[$];

    rv32i_boot_ctrl #(.IMEM_WORDS(IW), .WDT_CYCLES(WDT)) dut (
        .clk(clk), .rst(rst), .start(start),
        .load_valid(load_valid), .load_ready(load_ready),
        .load_data(load_data), .load_last(load_last),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .core_rst_n(core_rst_n), .core_halted(core_halted),
        .busy(busy), .done(done), .error(error), .err_code(err_code),
        .cycle_count(cycle_count), .load_count(load_count)
    );

    always #5 clk = ~clk;

    // Every memory write must match the oldest expected {addr, data}.
    always @(negedge clk) begin
        logic [AW+31:0] e;
        #2;
        if (imem_we === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_write: got addr %0d data %08h, required no write", imem_addr, imem_wdata);
            end else begin
                e = exp_q.pop_front();
                if ({imem_addr, imem_wdata} !== e)
                    $display("FAIL write: got addr %0d data %08h, required addr %0d data %08h",
                             imem_addr, imem_wdata, e[AW+31:32], e[31:0]);
                else n_pass++;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic load_words(input int n, input int base);
        logic [AW-1:0] a;
        for (int i = 0; i < n; i++) begin
            a          = AW'(base + i);
            load_valid = 1'b1;
            load_data  = $urandom;
            load_last  = (i == n - 1);
            exp_q.push_back({a, load_data});
            tick();
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_checks++; if ({core_rst_n, load_ready, imem_we, busy, done, error} !== 6'b0) $display("FAIL reset_flags: got %b required 000000", {core_rst_n, load_ready, imem_we, busy, done, error}); else n_pass++;
        n_checks++; if ({imem_addr, imem_wdata} !== '0) $display("FAIL reset_imem: got addr %0d data %08h required 0", imem_addr, imem_wdata); else n_pass++;
        n_checks++; if (err_code !== 2'b00) $display("FAIL reset_err_code: got %b required 00", err_code); else n_pass++;
        n_checks++; if ({cycle_count, load_count} !== '0) $display("FAIL reset_counts: got cyc %0d load %0d required 0", cycle_count, load_count); else n_pass++;
        rst = 1'b0;
        tick();
        n_checks++; if ({busy, core_rst_n, load_ready} !== 3'b000) $display("FAIL idle_flags: got %b required 000", {busy, core_rst_n, load_ready}); else n_pass++;
    endtask

    task automatic test_load_run();
        do_start();
        n_checks++; if ({busy, load_ready, core_rst_n} !== 3'b110) $display("FAIL load_entry: got %b required 110", {busy, load_ready, core_rst_n}); else n_pass++;
        load_words(5, 0);
        n_checks++; if ({busy, core_rst_n, load_ready} !== 3'b110) $display("FAIL run_entry: got %b required 110", {busy, core_rst_n, load_ready}); else n_pass++;
        n_checks++; if (load_count !== 16'd5) $display("FAIL load_count5: got %0d required 5", load_count); else n_pass++;
        n_checks++; if (exp_q.size() != 0) $display("FAIL load5_writes: got %0d pending required 0", exp_q.size()); else n_pass++;
        repeat (40) tick();
        n_checks++; if (cycle_count !== 32'd40) $display("FAIL run40_count: got %0d required 40", cycle_count); else n_pass++;
        core_halted = 1'b1;
        tick();
        core_halted = 1'b0;
        n_checks++; if ({done, busy, core_rst_n} !== 3'b101) $display("FAIL done_flags: got %b required 101", {done, busy, core_rst_n}); else n_pass++;
        repeat (3) tick();
        n_checks++; if (cycle_count !== 32'd40) $display("FAIL done_hold_count: got %0d required 40", cycle_count); else n_pass++;
    endtask

    task automatic test_back_to_back();
        do_start();
        n_checks++; if ({load_count, cycle_count, err_code} !== '0) $display("FAIL restart_clear: got load %0d cyc %0d err %b required 0", load_count, cycle_count, err_code); else n_pass++;
        n_checks++; if ({busy, core_rst_n, imem_addr} !== {2'b10, AW'(0)}) $display("FAIL restart_flags: got busy %b rst_n %b addr %0d required 1 0 0", busy, core_rst_n, imem_addr); else n_pass++;
    endtask

    task automatic test_gapped();
        int k = 0;
        logic [AW-1:0] a;
        for (int i = 0; i < 8; i++) begin
            load_valid = (i % 2 == 0);
            load_last  = (i == 6);
            load_data  = $urandom;
            start      = (i == 1);
            if (load_valid) begin
                a = AW'(k);
                exp_q.push_back({a, load_data});
                k++;
            end
            #1;
            if (i < 7) begin
                n_checks++; if (imem_we !== load_valid) $display("FAIL gap_we_%0d: got %b required %b", i, imem_we, load_valid); else n_pass++;
            end
            tick();
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        start      = 1'b0;
        n_checks++; if (load_count !== 16'd4) $display("FAIL gap_load_count: got %0d required 4", load_count); else n_pass++;
        n_checks++; if (cycle_count !== 32'd1) $display("FAIL gap_cycle_count: got %0d required 1", cycle_count); else n_pass++;
    endtask

    task automatic test_start_in_run();
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++; if ({busy, core_rst_n, load_count} !== {2'b11, 16'd4}) $display("FAIL run_start_ignored: got busy %b rst_n %b load %0d required 1 1 4", busy, core_rst_n, load_count); else n_pass++;
        n_checks++; if (cycle_count !== 32'd2) $display("FAIL run_start_count: got %0d required 2", cycle_count); else n_pass++;
        core_halted = 1'b1;
        tick();
        core_halted = 1'b0;
        n_checks++; if ({done, cycle_count} !== {1'b1, 32'd2}) $display("FAIL halt2: got done %b cyc %0d required 1 2", done, cycle_count); else n_pass++;
    endtask

    task automatic test_overflow();
        logic [AW-1:0] a;
        do_start();
        for (int i = 0; i < IW + 1; i++) begin
            load_valid = 1'b1;
            load_last  = 1'b0;
            load_data  = $urandom;
            if (i < IW) begin
                a = AW'(i);
                exp_q.push_back({a, load_data});
            end
            #1;
            n_checks++; if (load_ready !== (i < IW)) $display("FAIL ovf_ready_%0d: got %b required %b", i, load_ready, (i < IW)); else n_pass++;
            tick();
        end
        load_valid = 1'b0;
        n_checks++; if ({error, busy, core_rst_n, load_ready} !== 4'b1000) $display("FAIL ovf_flags: got %b required 1000", {error, busy, core_rst_n, load_ready}); else n_pass++;
        n_checks++; if (err_code !== 2'b01) $display("FAIL ovf_err_code: got %b required 01", err_code); else n_pass++;
        n_checks++; if ({load_count, imem_addr} !== {16'd8, AW'(IW - 1)}) $display("FAIL ovf_counts: got load %0d addr %0d required 8 7", load_count, imem_addr); else n_pass++;
        do_start();
        n_checks++; if ({error, err_code, busy} !== 4'b0001) $display("FAIL err_restart: got err %b code %b busy %b required 0 00 1", error, err_code, busy); else n_pass++;
    endtask

    task automatic test_rst_mid_run();
        load_words(2, 0);
        repeat (7) tick();
        n_checks++; if (cycle_count !== 32'd7) $display("FAIL pre_rst_count: got %0d required 7", cycle_count); else n_pass++;
        rst = 1'b1;
        start = 1'b1;
        tick();
        rst = 1'b0;
        start = 1'b0;
        n_checks++; if ({core_rst_n, busy, done, error, load_ready} !== 5'b0) $display("FAIL rst_run_flags: got %b required 00000", {core_rst_n, busy, done, error, load_ready}); else n_pass++;
        n_checks++; if ({cycle_count, load_count, err_code, imem_addr} !== '0) $display("FAIL rst_run_counts: got cyc %0d load %0d err %b addr %0d required 0", cycle_count, load_count, err_code, imem_addr); else n_pass++;
        do_start();
        load_words(3, 0);
        n_checks++; if ({load_count, core_rst_n} !== {16'd3, 1'b1}) $display("FAIL reload: got load %0d rst_n %b required 3 1", load_count, core_rst_n); else n_pass++;
        core_halted = 1'b1;
        tick();
        core_halted = 1'b0;
    endtask

    task automatic test_watchdog();
        do_start();
        load_words(1, 0);
        repeat (WDT) tick();
        n_checks++; if ({busy, cycle_count} !== {1'b1, 32'(WDT)}) $display("FAIL wdt_limit: got busy %b cyc %0d required 1 %0d", busy, cycle_count, WDT); else n_pass++;
`ifdef BOOT_CTRL_WATCHDOG_EN
        tick();
        n_checks++; if ({error, err_code, cycle_count} !== {3'b110, 32'(WDT)}) $display("FAIL wdt_expire: got err %b code %b cyc %0d required 1 10 %0d", error, err_code, cycle_count, WDT); else n_pass++;
        do_start();
        load_words(1, 0);
        repeat (WDT) tick();
        core_halted = 1'b1;
        tick();
        core_halted = 1'b0;
        n_checks++; if ({done, error, err_code, cycle_count} !== {4'b1000, 32'(WDT)}) $display("FAIL wdt_tie: got done %b err %b code %b cyc %0d required 1 0 00 %0d", done, error, err_code, cycle_count, WDT); else n_pass++;
`else
        repeat (5) tick();
        n_checks++; if ({busy, err_code, cycle_count} !== {3'b100, 32'(WDT + 5)}) $display("FAIL no_wdt: got busy %b code %b cyc %0d required 1 00 %0d", busy, err_code, cycle_count, WDT + 5); else n_pass++;
        core_halted = 1'b1;
        tick();
        core_halted = 1'b0;
        n_checks++; if (done !== 1'b1) $display("FAIL no_wdt_halt: got %b required 1", done); else n_pass++;
`endif
    endtask

    initial begin
        test_reset();
        test_load_run();
        test_back_to_back();
        test_gapped();
        test_start_in_run();
        test_overflow();
        test_rst_mid_run();
        test_watchdog();
        tick();
        n_checks++; if (exp_q.size() != 0) $display("FAIL pending_writes: got %0d required 0", exp_q.size()); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rv32i_boot_ctrl.md
RV32I_BOOT_CTRL -- requirements
Module: rv32i_boot_ctrl

Interface
REQ-001 Parameter IMEM_WORDS, default 256: instruction memory depth in 32-bit words, power of two, minimum 4.
REQ-002 Parameter WDT_CYCLES, default 100000: run-phase watchdog limit in clock cycles, minimum 1.
REQ-003 The block SHALL use one clock and a synchronous active-high reset; every port is sampled or driven on the rising edge of clk.
REQ-004 Port list (name, direction, width, meaning), one per line:
  clk  in  1  system clock.
  rst  in  1  synchronous active-high reset.
  start  in  1  pulse that begins a load+run sequence.
  load_valid  in  1  program word available.
  load_ready  out  1  controller accepts a program word.
  load_data  in  32  program word.
  load_last  in  1  current word is the final program word.
  imem_we  out  1  instruction memory write strobe.
  imem_addr  out  $clog2(IMEM_WORDS)  instruction memory word address.
  imem_wdata  out  32  instruction memory write data.
  core_rst_n  out  1  active-low reset to the core.
  core_halted  in  1  core has executed its halt instruction.
  busy  out  1  high in LOAD or RUN.
  done  out  1  high in DONE.
  error  out  1  high in ERR.
  err_code  out  2  00 none, 01 overflow, 10 timeout.
  cycle_count  out  32  number of cycles spent in RUN.
  load_count  out  16  number of words written in the current load.

Function
REQ-005 States: IDLE, LOAD, RUN, DONE, ERR; exactly one state is active per cycle.
REQ-006 IDLE: core_rst_n=0, load_ready=0; start=1 -> LOAD.
REQ-007 LOAD entry: address counter, load_count, cycle_count and err_code are cleared to 0.
REQ-008 LOAD: load_ready=1 and core_rst_n=0.
REQ-009 Handshake: a word is accepted in a cycle where load_valid and load_ready are both high.
REQ-010 On acceptance, in the same cycle (combinational): imem_we=1, imem_addr=address counter, imem_wdata=load_data.
REQ-011 On acceptance, the address counter and load_count each increment by 1 at the next edge.
REQ-012 imem_we SHALL be 0 in every cycle without an accepted word.
REQ-013 Accepted word with load_last=1 -> RUN at the next edge; that word is written normally.
REQ-014 Accepted word at address IMEM_WORDS-1 with load_last=0 -> ERR with err_code=01; the word is still written and the address counter does not wrap.
REQ-015 RUN: core_rst_n=1, load_ready=0; cycle_count increments by 1 each RUN cycle and saturates at 32'hFFFFFFFF.
REQ-016 RUN: core_halted=1 -> DONE; cycle_count holds its value.
REQ-017 DONE: core_rst_n stays 1 so core state remains inspectable; done=1.
REQ-018 DONE or ERR: start=1 -> LOAD, and core_rst_n returns to 0 from the first LOAD cycle.
REQ-019 ERR: core_rst_n=0, error=1; err_code holds until the next LOAD entry.
REQ-020 start is ignored in LOAD and RUN.
REQ-021 load_valid and load_last are ignored outside LOAD.
REQ-022 core_halted is ignored outside RUN.

Reset
REQ-023 rst=1 forces IDLE at the next edge, regardless of the current state, including mid-LOAD and mid-RUN.
REQ-024 Outputs after reset: core_rst_n=0, load_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, busy=0, done=0, error=0, err_code=00, cycle_count=0, load_count=0.
REQ-025 rst has priority over start and all other inputs.

Configuration
REQ-026 Macro BOOT_CTRL_WATCHDOG_EN.
  Defined: when cycle_count reaches WDT_CYCLES in RUN with core_halted=0, the block enters ERR with err_code=10.
  Defined, simultaneous event: core_halted=1 in the same cycle takes priority and the block enters DONE.
  Undefined: no timeout; RUN exits only on halt, rst or nothing else, and err_code=10 is never produced.

Verification
REQ-027 Load 5 words, last on the 5th -> writes at addresses 0..4, load_count=5, RUN entered; halted asserted after 40 cycles -> DONE, cycle_count=40, core_rst_n=1.
REQ-028 IMEM_WORDS=4, stream 5 words with no last -> 4 writes, ERR with err_code=01 after the 4th handshake, and the 5th word is not accepted (load_ready=0).
REQ-029 load_valid toggles every other cycle during LOAD -> imem_we pulses only on handshake cycles and addresses remain contiguous.
REQ-030 BOOT_CTRL_WATCHDOG_EN defined, WDT_CYCLES=10, halted never asserted -> ERR with err_code=10 and cycle_count=10; with halted and timeout in the same cycle -> DONE.
REQ-031 rst pulsed mid-RUN at cycle 7 -> IDLE next edge, core_rst_n=0, all outputs at reset values; a subsequent start -> clean reload from address 0.
REQ-032 start pulsed during RUN -> no effect; start pulsed in DONE -> LOAD with counters cleared.
